// File: rtl/max_pool_pack_pkg.sv
// Shared sizing, state encoding and byte-index helper for the max-pool packer,
// also used by the FC-stage bench and the top level.
package max_pool_pack_pkg;

    localparam int DW    = 8;
    localparam int CH    = 3;
    localparam int IN_W  = 6;
    localparam int POOL  = 2;
    localparam int OUT_W = IN_W / POOL;
    localparam int NOUT  = CH * OUT_W * OUT_W;

    localparam int CW = $clog2(IN_W);
    localparam int HW = $clog2(CH);
    localparam int PW = $clog2(NOUT);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CW-1:0] POS_LAST = CW'(IN_W - 1);
    localparam logic [CW-1:0] POS_ONE  = CW'(1);
    localparam logic [CW-1:0] POS_ZERO = CW'(0);
    localparam logic [HW-1:0] CH_LAST  = HW'(CH - 1);
    localparam logic [HW-1:0] CH_ONE   = HW'(1);
    localparam logic [HW-1:0] CH_ZERO  = HW'(0);

    // Pooled byte that input pixel (ch,row,col) folds into.
    function automatic logic [PW-1:0] byte_index(input logic [HW-1:0] ch,
                                                 input logic [CW-1:0] row,
                                                 input logic [CW-1:0] col);
        int p;
        p = int'(ch) * OUT_W * OUT_W + int'(row[CW-1:1]) * OUT_W + int'(col[CW-1:1]);
        return PW'(p);
    endfunction

endpackage

// File: rtl/max_pool_pack_max2_u.sv
// Combinational unsigned 2-input max; operand a wins ties so a stored byte is kept.
module max2_u
    import max_pool_pack_pkg::*;
#(
    parameter int W = DW
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    // Select the larger operand.
    always_comb begin
        y = a;
        if (b > a) begin
            y = b;
        end else begin
            y = a;
        end
    end

endmodule

// File: rtl/max_pool_pack.sv
// Streams one conv feature map per frame, max-pools 2x2/stride-2 per channel
// and holds the packed result on pool_lin until the FC stage takes it.
module max_pool_pack
    import max_pool_pack_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NOUT*DW-1:0]   pool_lin
);

    state_t          state_r;
    logic [CW-1:0]   col_r;
    logic [CW-1:0]   row_r;
    logic [HW-1:0]   ch_r;
    logic [DW-1:0]   mem_r [NOUT];
    logic            in_ready_r;
    logic            out_valid_r;

    logic            accept_s;
    logic            first_s;
    logic [PW-1:0]   p_s;
    logic [DW-1:0]   max_s;
    logic [DW-1:0]   next_byte_s;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;

    // Decode the target byte and the value it takes on this accept.
    always_comb begin
        accept_s = in_valid && in_ready_r;
        p_s      = byte_index(ch_r, row_r, col_r);
        first_s  = !row_r[0] && !col_r[0];
        if (first_s) begin
            next_byte_s = in_data;
        end else begin
            next_byte_s = max_s;
        end
    end

    max2_u #(.W(DW)) u_max2 (
        .a (mem_r[p_s]),
        .b (in_data),
        .y (max_s)
    );

    // Frame FSM: counters, byte storage and handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= FILL;
            col_r       <= POS_ZERO;
            row_r       <= POS_ZERO;
            ch_r        <= CH_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            for (int i = 0; i < NOUT; i++) begin
                mem_r[i] <= {DW{1'b0}};
            end
        end else begin
            case (state_r)
                FILL: begin
                    if (accept_s) begin
                        mem_r[p_s] <= next_byte_s;
                        if (col_r == POS_LAST) begin
                            col_r <= POS_ZERO;
                            if (row_r == POS_LAST) begin
                                row_r <= POS_ZERO;
                                if (ch_r == CH_LAST) begin
                                    ch_r        <= CH_ZERO;
                                    state_r     <= HOLD;
                                    in_ready_r  <= 1'b0;
                                    out_valid_r <= 1'b1;
                                end else begin
                                    ch_r <= ch_r + CH_ONE;
                                end
                            end else begin
                                row_r <= row_r + POS_ONE;
                            end
                        end else begin
                            col_r <= col_r + POS_ONE;
                        end
                    end
                end
                HOLD: begin
                    // The handshake cycle itself is the inter-frame bubble.
                    if (out_ready) begin
                        state_r     <= FILL;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= FILL;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Flatten the byte array onto the packed output vector.
    always_comb begin
        pool_lin = {(NOUT*DW){1'b0}};
        for (int p = 0; p < NOUT; p++) begin
            pool_lin[p*DW +: DW] = mem_r[p];
        end
    end

endmodule

// File: tb/tb_max_pool_pack.sv
// Self-checking bench for max_pool_pack: table-driven frames plus hand-written
// backpressure, reset-abort and back-to-back sequences, scoreboarded on out_valid.
module tb_max_pool_pack;
    import max_pool_pack_pkg::*;

    localparam int NPIX = CH * IN_W * IN_W;
    localparam int NV   = 5;

    typedef enum logic [1:0] {M_RAMP, M_ROT200, M_CONST, M_RAND} mode_e;
    typedef struct packed {
        mode_e              mode;
        logic [DW-1:0]      fill;
        logic               gaps;
        logic [NOUT*DW-1:0] exp;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [DW-1:0]      in_data;
    logic               out_valid;
    logic               out_ready;
    logic [NOUT*DW-1:0] pool_lin;

    int total = 0;
    int bad = 0;
    int acc_cnt = 0;
    int stall_cnt = 0;
    int frames_out = 0;

    logic [DW-1:0]      pix [NPIX];
    logic [NOUT*DW-1:0] sb [$];
    vec_t               vecs [NV];

    always #5 clk = ~clk;

    max_pool_pack dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pool_lin  (pool_lin)
    );

    task automatic chk_vec(input string name, input logic [NOUT*DW-1:0] act, input logic [NOUT*DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic gen(input mode_e m, input logic [DW-1:0] fill);
        int n, c, pr, pc, q;
        for (int k = 0; k < NPIX; k++) begin
            case (m)
                M_RAMP:  pix[k] = DW'(k);
                M_CONST: pix[k] = fill;
                M_RAND:  pix[k] = DW'($urandom_range(0, 255));
                default: pix[k] = 8'd0;
            endcase
        end
        if (m == M_ROT200) begin
            for (n = 0; n < NOUT; n++) begin
                c  = n / 9;
                pr = (n % 9) / 3;
                pc = n % 3;
                q  = n % 4;
                pix[c*36 + (2*pr + q/2)*6 + 2*pc + q%2] = 8'd200;
            end
        end
    endtask

    // Reference pooling over the whole stored frame.
    task automatic model(output logic [NOUT*DW-1:0] e);
        logic [DW-1:0] m, v;
        e = '0;
        for (int c = 0; c < CH; c++)
            for (int pr = 0; pr < OUT_W; pr++)
                for (int pc = 0; pc < OUT_W; pc++) begin
                    m = 8'd0;
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++) begin
                            v = pix[c*IN_W*IN_W + (2*pr+dr)*IN_W + 2*pc + dc];
                            if (v > m) m = v;
                        end
                    e[(c*OUT_W*OUT_W + pr*OUT_W + pc)*DW +: DW] = m;
                end
    endtask

    task automatic send(input int n, input bit gaps);
        int waited, g;
        bit ok;
        for (int k = 0; k < n; k++) begin
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            if (g > 0) begin
                in_valid = 1'b0;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = pix[k];
            ok = 1'b0;
            waited = 0;
            while (!ok) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
                waited++;
                if (!ok && waited > 1000) begin
                    $display("FAIL send_timeout: pixel %0d waited %0d cycles want <1000", k, waited);
                    bad++;
                    $fatal(1, "stalled input");
                end
            end
        end
    endtask

    task automatic wait_frames(input int target);
        int t = 0;
        while (frames_out < target && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk_int("frame_arrival", frames_out, target);
    endtask

    // Input-side accounting at the active edge.
    initial forever begin
        @(posedge clk);
        if (!rst && in_valid && in_ready) acc_cnt++;
        if (!rst && in_valid && !in_ready) stall_cnt++;
    end

    // Output monitor: scoreboard pop on out_valid rise, stability while held.
    initial begin
        logic prev_ov;
        logic [NOUT*DW-1:0] held;
        prev_ov = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_ov) begin
                frames_out++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got %h want none", pool_lin);
                end else begin
                    held = sb.pop_front();
                    chk_vec("frame", pool_lin, held);
                end
            end else if (out_valid) begin
                chk_vec("hold_stable", pool_lin, held);
            end
            if (out_valid) chk_int("ready_low_in_hold", int'(in_ready), 0);
            prev_ov = rst ? 1'b0 : out_valid;
        end
    end

    initial begin
        logic [NOUT*DW-1:0] ramp_exp, e;
        int a0, f0, s0;

        for (int c = 0; c < CH; c++)
            for (int pr = 0; pr < OUT_W; pr++)
                for (int pc = 0; pc < OUT_W; pc++)
                    ramp_exp[(c*9 + pr*3 + pc)*DW +: DW] = DW'(c*36 + (2*pr+1)*6 + 2*pc + 1);
        vecs[0] = '{mode: M_RAMP,   fill: 8'd0,   gaps: 1'b0, exp: ramp_exp};
        vecs[1] = '{mode: M_ROT200, fill: 8'd0,   gaps: 1'b0, exp: {NOUT{8'd200}}};
        vecs[2] = '{mode: M_CONST,  fill: 8'd255, gaps: 1'b0, exp: {NOUT{8'd255}}};
        vecs[3] = '{mode: M_RAMP,   fill: 8'd0,   gaps: 1'b1, exp: ramp_exp};
        vecs[4] = '{mode: M_CONST,  fill: 8'd0,   gaps: 1'b0, exp: {NOUT{8'd0}}};

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_vec("reset_pool", pool_lin, {(NOUT*DW){1'b0}});
        chk_int("reset_out_valid", int'(out_valid), 0);
        chk_int("reset_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            gen(vecs[i].mode, vecs[i].fill);
            sb.push_back(vecs[i].exp);
            a0 = acc_cnt;
            f0 = frames_out;
            send(NPIX, vecs[i].gaps);
            in_valid = 1'b0;
            wait_frames(f0 + 1);
            chk_int("accepts", acc_cnt - a0, NPIX);
        end

        // Backpressure: pixels offered during HOLD must not be consumed.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        gen(M_RAMP, 8'd0);
        sb.push_back(ramp_exp);
        f0 = frames_out;
        send(NPIX, 1'b0);
        in_data = 8'hAA;
        wait_frames(f0 + 1);
        a0 = acc_cnt;
        repeat (20) begin
            @(negedge clk);
            chk_int("bp_out_valid", int'(out_valid), 1);
        end
        chk_int("bp_no_accept", acc_cnt - a0, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_int("bp_release_valid", int'(out_valid), 0);
        chk_int("bp_release_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Reset mid-frame, then an all-9 frame.
        gen(M_RAND, 8'd0);
        send(50, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_vec("abort_pool", pool_lin, {(NOUT*DW){1'b0}});
        chk_int("abort_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        gen(M_CONST, 8'd9);
        sb.push_back({NOUT{8'd9}});
        f0 = frames_out;
        send(NPIX, 1'b0);
        in_valid = 1'b0;
        wait_frames(f0 + 1);
        repeat (10) @(negedge clk);
        chk_int("abort_frames", frames_out - f0, 1);
        @(posedge clk);
        #1;

        // Back-to-back random frames with continuous in_valid.
        s0 = stall_cnt;
        f0 = frames_out;
        for (int i = 0; i < 100; i++) begin
            gen(M_RAND, 8'd0);
            model(e);
            sb.push_back(e);
            send(NPIX, 1'b0);
        end
        in_valid = 1'b0;
        wait_frames(f0 + 100);
        chk_int("b2b_bubbles", stall_cnt - s0, 99);
        repeat (5) @(negedge clk);
        chk_int("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
